// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory request path.
//   - store/load type encodings as carried on req_store_type / req_load_type
//   - responder FSM state enum
//   - access_err : alignment / reserved-type check for a request
//   - store_be   : byte-lane write enables for a store
//   - store_data : store data replicated into the lanes it targets
//   - load_ext   : byte/half selection plus sign/zero extension of a read word
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_SB  = 2'b00,
        ST_SH  = 2'b01,
        ST_SW  = 2'b10,
        ST_RSV = 2'b11
    } store_type_t;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_type_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } mem_state_t;

    // Misaligned halfword/word or any reserved encoding.
    function automatic logic access_err(logic wr, logic [1:0] st, logic [2:0] lt,
                                        logic [1:0] a);
        logic err;
        err = 1'b1;
        if (wr) begin
            case (st)
                ST_SB:   err = 1'b0;
                ST_SH:   err = a[0];
                ST_SW:   err = (a != 2'b00);
                default: err = 1'b1;
            endcase
        end else begin
            case (lt)
                LD_LB, LD_LBU: err = 1'b0;
                LD_LH, LD_LHU: err = a[0];
                LD_LW:         err = (a != 2'b00);
                default:       err = 1'b1;
            endcase
        end
        return err;
    endfunction

    function automatic logic [3:0] store_be(logic [1:0] st, logic [1:0] a);
        logic [3:0] be;
        case (st)
            ST_SB:   be = 4'b0001 << a;
            ST_SH:   be = a[1] ? 4'b1100 : 4'b0011;
            ST_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicating the low bytes lets the byte enables alone pick the lanes.
    function automatic logic [31:0] store_data(logic [1:0] st, logic [31:0] d);
        logic [31:0] r;
        case (st)
            ST_SB:   r = {4{d[7:0]}};
            ST_SH:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(logic [2:0] lt, logic [1:0] a,
                                             logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {a, 3'b000};
        case (lt)
            LD_LB:   r = {{24{sh[7]}}, sh[7:0]};
            LD_LBU:  r = {24'd0, sh[7:0]};
            LD_LH:   r = {{16{sh[15]}}, sh[15:0]};
            LD_LHU:  r = {16'd0, sh[15:0]};
            LD_LW:   r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bus between the MEM-stage initiator (master)
// and the memory responder (slave).
//   req_*  : request channel, valid/ready handshake
//   resp_* : response channel, valid/ready handshake
interface data_mem_responder_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_store_type;
    logic [2:0]        req_load_type;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_store_type,
               req_load_type, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_store_type,
               req_load_type, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32-bit data storage.
//   clk   : write clock
//   we    : write strobe, qualified per byte by be
//   be    : byte-lane enables
//   addr  : word index shared by read and write
//   wdata : lane-replicated write data
//   rdata : combinational read of mem[addr]
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder with programmable access latency.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of data_mem_responder_if (request + response channels)
// One request is outstanding at a time. The access (array write or read and
// extension) happens on the edge that enters RESP, exactly LATENCY cycles
// after the accepting edge; the response is then held until resp_ready.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_responder_if.slave bus
);
    localparam int         IDX_W    = ADDR_W - 2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    mem_state_t        state;
    logic [3:0]        cnt;

    logic              h_write;
    logic [ADDR_W-1:0] h_addr;
    logic [31:0]       h_wdata;
    logic [1:0]        h_st;
    logic [2:0]        h_lt;

    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic              accept;
    logic              commit;
    logic              a_write;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic [1:0]        a_st;
    logic [2:0]        a_lt;
    logic              a_err;
    logic              mem_we;
    logic [31:0]       rd_word;
    logic [31:0]       ld_data;

    // Gated by rst so ready drops as soon as reset is asserted.
    assign bus.req_ready  = rst && (state == S_IDLE);
    assign accept         = bus.req_valid && bus.req_ready;

    // With LATENCY=1 the access happens on the accepting edge itself, before
    // the holding registers are loaded, so IDLE takes the fields straight
    // from the bus.
    always_comb begin
        a_write = h_write;
        a_addr  = h_addr;
        a_wdata = h_wdata;
        a_st    = h_st;
        a_lt    = h_lt;
        if (state == S_IDLE) begin
            a_write = bus.req_write;
            a_addr  = bus.req_addr;
            a_wdata = bus.req_wdata;
            a_st    = bus.req_store_type;
            a_lt    = bus.req_load_type;
        end
    end

    assign commit  = (state == S_WAIT && cnt == 4'd0) || (LATENCY == 1 && accept);
    assign a_err   = access_err(a_write, a_st, a_lt, a_addr[1:0]);
    assign mem_we  = commit && a_write && !a_err;
    assign ld_data = load_ext(a_lt, a_addr[1:0], rd_word);

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (store_be(a_st, a_addr[1:0])),
        .addr  (a_addr[ADDR_W-1:2]),
        .wdata (store_data(a_st, a_wdata)),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            h_write      <= 1'b0;
            h_addr       <= '0;
            h_wdata      <= '0;
            h_st         <= '0;
            h_lt         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        h_write <= bus.req_write;
                        h_addr  <= bus.req_addr;
                        h_wdata <= bus.req_wdata;
                        h_st    <= bus.req_store_type;
                        h_lt    <= bus.req_load_type;
                        cnt     <= CNT_INIT;
                        state   <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    else             state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        state        <= S_IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (commit) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= a_err;
                resp_rdata_q <= (a_write || a_err) ? 32'd0 : ld_data;
            end
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (target) end of the data-memory request interface that the MEM stage drives.
- Accepts one load/store request at a time over a valid/ready handshake.
- Performs the access against an internal word-organised array after a programmable wait, then returns the load data or completion over a valid/ready response channel.
- Sits between the pipeline's memory-request initiator and the data storage. Models slow memory so stall logic can be exercised.

Parameters:
- ADDR_W, 12, byte-address width; word index is addr[ADDR_W-1:2].
- DEPTH, 1024, number of 32-bit words (must equal 2^(ADDR_W-2)).
- LATENCY, 2, cycles from request acceptance to resp_valid assertion; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-aligned
- req_store_type  input  2  00 SB, 01 SH, 10 SW, 11 reserved
- req_load_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, others reserved
- resp_valid  output  1  response present
- resp_ready  input  1  initiator consumes response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned access or reserved type

Behaviour:
- Reset (rst low, async): FSM to IDLE, wait counter 0, req_ready=0 while rst is low. After release: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. The memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, the request fields are captured into holding registers.
  - Counter is loaded with LATENCY-1.
  - Next state is WAIT, or RESP if LATENCY=1.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - At count 0, the access is performed and the FSM enters RESP on the same edge.
  - Resulting latency: accept edge to resp_valid high is exactly LATENCY cycles.
- Access, at the WAIT->RESP (or IDLE->RESP) edge:
  - Load: word read; byte/half selected by addr[1:0]; sign-extended for LB/LH, zero-extended for LBU/LHU.
  - Store: byte-lane write-enable from store_type and addr[1:0]. SB writes lane addr[1:0]. SH writes lanes {addr[1],0} and {addr[1],1}. SW writes all lanes. Data is replicated into the lanes.
- Error: SH/LH/LHU with addr[0]=1, SW/LW with addr[1:0]!=0, or a reserved type. Result: resp_err=1, no array write, resp_rdata=0.
- RESP:
  - resp_valid=1; resp_rdata/resp_err held stable until handshake.
  - On resp_ready, next state is IDLE.
  - A new request cannot be accepted in the same cycle; req_ready rises the cycle after the response handshake.
- Request fields are ignored when req_ready=0.
- Address bits above the word index are unused; address wraps modulo DEPTH words.
- Reset mid-WAIT or mid-RESP: in-flight request is discarded; a store not yet committed is not written.

Decomposition:
- Shared package (riscv_mem_pkg):
  - store-type and load-type encodings.
  - FSM state enum.
  - A function computing byte-enable from store_type/addr[1:0].
  - A function extending load data from load_type/addr[1:0].
- One natural sub-module: dmem_array. It holds the DEPTH x 32 array with a 4-bit byte-enable write port and a combinational read port. The FSM, counter and handshake stay in the top.

Test Plan:
- Reset, then SW addr 0x010 data 0xDEADBEEF, LATENCY=2 -> resp_valid exactly 2 cycles after accept, resp_err=0, resp_rdata=0. Then LW 0x010 -> 0xDEADBEEF.
- After the above, SB addr 0x013 data 0x000000A5, then LW 0x010 -> 0xA5ADBEEF. Then LB 0x013 -> 0xFFFFFFA5, and LBU 0x013 -> 0x000000A5.
- SH addr 0x022 data 0x00008001, then LH 0x022 -> 0xFFFF8001 and LHU 0x022 -> 0x00008001. Then LW 0x020 -> upper half 0x8001, lower half unchanged.
- Misaligned LW 0x011 and SH 0x021 -> resp_err=1, resp_rdata=0. A following LW 0x020 shows no change.
- Hold resp_ready=0 for 5 cycles during RESP -> resp_valid and resp_rdata stable, req_ready=0. Assert resp_ready -> req_ready=1 the next cycle.
- Assert rst low during WAIT of SW 0x030 data 0x12345678 -> outputs reset immediately. After release, LW 0x030 returns the prior contents, not 0x12345678.
